// File: rtl/misc_cmt_unit_pkg.sv
// rtl/misc_cmt_unit_pkg.sv - shared widths, packet struct and state enum for the misc commit unit
package misc_cmt_unit_pkg;

  localparam int CMT_ROB_IDX_W     = 6;
  localparam int CMT_PREG_W        = 6;
  localparam int CMT_VALEN         = 32;
  localparam int CMT_TLB_ENTRY_NUM = 16;
  localparam int CMT_TLB_IDX_W     = $clog2(CMT_TLB_ENTRY_NUM);

  typedef enum logic [3:0] {
    PRIV_NONE     = 4'd0,
    PRIV_CSR_RD   = 4'd1,
    PRIV_CSR_WR   = 4'd2,
    PRIV_CSR_XCHG = 4'd3,
    PRIV_TLBSRCH  = 4'd4,
    PRIV_TLBRD    = 4'd5,
    PRIV_TLBWR    = 4'd6,
    PRIV_TLBFILL  = 4'd7,
    PRIV_INVTLB   = 4'd8,
    PRIV_CACOP    = 4'd9,
    PRIV_ERTN     = 4'd10,
    PRIV_IDLE     = 4'd11
  } PrivOpType;

  typedef struct packed {
    logic                     valid;
    logic [CMT_ROB_IDX_W-1:0] rob_idx;
    logic                     we;
    logic [CMT_PREG_W-1:0]    pdest;
    logic [31:0]              wdata;
  } MiscCmtBaseSt;

  typedef struct packed {
    MiscCmtBaseSt             base;
    logic                     br_inst;
    logic                     br_redirect;
    logic [CMT_VALEN-1:0]     br_target;
    PrivOpType                priv_op;
    logic                     csr_we;
    logic [13:0]              csr_waddr;
    logic [31:0]              csr_wdata;
    logic                     tlbsrch_found;
    logic [CMT_TLB_IDX_W-1:0] tlbsrch_idx;
    logic [31:0]              tlbrd_ehi;
    logic [31:0]              tlbrd_elo0;
    logic [31:0]              tlbrd_elo1;
    logic [31:0]              tlbrd_idx;
    logic [9:0]               tlbrd_asid;
    logic [4:0]               invtlb_op;
    logic [9:0]               invtlb_asid;
    logic [CMT_VALEN-1:0]     invtlb_vaddr;
    logic [4:0]               cacop_op;
    logic [CMT_VALEN-1:0]     cacop_vaddr;
  } MiscCmtSt;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEAD   = 3'd1,
    ST_CACHE  = 3'd2,
    ST_TLB    = 3'd3,
    ST_RETIRE = 3'd4
  } MiscCmtStateT;

  // The buffered instruction may commit only once the ROB head points at it.
  function automatic logic head_match(input logic                     head_valid,
                                      input logic [CMT_ROB_IDX_W-1:0] head_idx,
                                      input logic [CMT_ROB_IDX_W-1:0] buf_idx);
    return head_valid && (head_idx == buf_idx);
  endfunction

endpackage

// File: rtl/misc_cmt_buf.sv
// rtl/misc_cmt_buf.sv - single-entry holding buffer for one misc result plus its drop flag
module misc_cmt_buf
  import misc_cmt_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_load,
  input  logic     i_clear,
  input  logic     i_set_drop,
  input  MiscCmtSt i_pkt,
  output MiscCmtSt o_buf,
  output logic     o_drop
);

  MiscCmtSt r_buf;
  logic     r_drop;

  // Clear wins over load so a flush can never capture a packet; drop is sticky until the entry leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_drop <= 1'b0;
    end else if (i_clear) begin
      r_buf  <= '0;
      r_drop <= 1'b0;
    end else if (i_load) begin
      r_buf  <= i_pkt;
      r_drop <= 1'b0;
    end else if (i_set_drop) begin
      r_drop <= 1'b1;
    end
  end

  assign o_buf  = r_buf;
  assign o_drop = r_drop;

endmodule

// File: rtl/misc_cmt_unit.sv
// rtl/misc_cmt_unit.sv - misc pipe commit unit: waits for ROB head, issues side effects, retires (optional MISC_CMT_PERF_EN counters)
module misc_cmt_unit
  import misc_cmt_unit_pkg::*;
#(
  parameter int ROB_IDX_W = CMT_ROB_IDX_W,
  parameter int PREG_W    = CMT_PREG_W,
  parameter int VALEN     = CMT_VALEN,
  parameter int TLB_IDX_W = CMT_TLB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  MiscCmtSt             cmt_i,
  output logic                 cmt_ready_o,
  input  logic                 rob_head_valid_i,
  input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
  output logic                 csr_we_o,
  output logic [13:0]          csr_waddr_o,
  output logic [31:0]          csr_wdata_o,
  output logic                 tlbsrch_we_o,
  output logic                 tlbsrch_found_o,
  output logic [TLB_IDX_W-1:0] tlbsrch_idx_o,
  output logic                 tlbrd_we_o,
  output logic [31:0]          tlbrd_ehi_o,
  output logic [31:0]          tlbrd_elo0_o,
  output logic [31:0]          tlbrd_elo1_o,
  output logic [31:0]          tlbrd_idx_o,
  output logic [9:0]           tlbrd_asid_o,
  output logic                 invtlb_valid_o,
  output logic [4:0]           invtlb_op_o,
  output logic [9:0]           invtlb_asid_o,
  output logic [VALEN-1:0]     invtlb_vaddr_o,
  input  logic                 invtlb_ready_i,
  output logic                 cacop_valid_o,
  output logic [4:0]           cacop_op_o,
  output logic [VALEN-1:0]     cacop_vaddr_o,
  input  logic                 cacop_ready_i,
  output logic                 redirect_valid_o,
  output logic [VALEN-1:0]     redirect_pc_o,
  output logic                 retire_valid_o,
  output logic [ROB_IDX_W-1:0] retire_rob_idx_o,
  output logic                 retire_we_o,
  output logic [PREG_W-1:0]    retire_pdest_o,
  output logic [31:0]          retire_wdata_o
`ifdef MISC_CMT_PERF_EN
  ,
  output logic [31:0]          perf_br_cnt_o,
  output logic [31:0]          perf_redirect_cnt_o
`endif
);

  MiscCmtStateT r_state;
  MiscCmtStateT w_state_nxt;
  MiscCmtSt     w_buf;
  logic         w_drop;
  logic         w_load;
  logic         w_clear;
  logic         w_set_drop;
  logic         w_head_hit;

  misc_cmt_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_set_drop (w_set_drop),
    .i_pkt      (cmt_i),
    .o_buf      (w_buf),
    .o_drop     (w_drop)
  );

  assign w_head_hit = head_match(rob_head_valid_i & w_buf.base.valid, rob_head_idx_i, w_buf.base.rob_idx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, buffer control and the single-cycle commit strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_load           = 1'b0;
    w_clear          = 1'b0;
    w_set_drop       = 1'b0;
    cmt_ready_o      = 1'b0;
    cacop_valid_o    = 1'b0;
    invtlb_valid_o   = 1'b0;
    retire_valid_o   = 1'b0;
    csr_we_o         = 1'b0;
    tlbsrch_we_o     = 1'b0;
    tlbrd_we_o       = 1'b0;
    redirect_valid_o = 1'b0;
    retire_we_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmt_ready_o = 1'b1;
        if (flush_i) begin
          w_clear = 1'b1;
        end else if (cmt_i.base.valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (flush_i) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_head_hit) begin
          case (w_buf.priv_op)
            PRIV_CACOP:  w_state_nxt = ST_CACHE;
            PRIV_INVTLB: w_state_nxt = ST_TLB;
            default:     w_state_nxt = ST_RETIRE;
          endcase
        end
      end
      ST_CACHE: begin
        // The request is already visible downstream, so it is held until taken even if flushed.
        cacop_valid_o = 1'b1;
        if (cacop_ready_i) begin
          if (w_drop || flush_i) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RETIRE;
          end
        end else if (flush_i) begin
          w_set_drop = 1'b1;
        end
      end
      ST_TLB: begin
        invtlb_valid_o = 1'b1;
        if (invtlb_ready_i) begin
          if (w_drop || flush_i) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RETIRE;
          end
        end else if (flush_i) begin
          w_set_drop = 1'b1;
        end
      end
      ST_RETIRE: begin
        retire_valid_o   = 1'b1;
        csr_we_o         = w_buf.csr_we;
        tlbsrch_we_o     = (w_buf.priv_op == PRIV_TLBSRCH);
        tlbrd_we_o       = (w_buf.priv_op == PRIV_TLBRD);
        redirect_valid_o = w_buf.br_inst & w_buf.br_redirect;
        retire_we_o      = w_buf.base.we;
        w_clear          = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign csr_waddr_o      = w_buf.csr_waddr;
  assign csr_wdata_o      = w_buf.csr_wdata;
  assign tlbsrch_found_o  = w_buf.tlbsrch_found;
  assign tlbsrch_idx_o    = w_buf.tlbsrch_idx;
  assign tlbrd_ehi_o      = w_buf.tlbrd_ehi;
  assign tlbrd_elo0_o     = w_buf.tlbrd_elo0;
  assign tlbrd_elo1_o     = w_buf.tlbrd_elo1;
  assign tlbrd_idx_o      = w_buf.tlbrd_idx;
  assign tlbrd_asid_o     = w_buf.tlbrd_asid;
  assign invtlb_op_o      = w_buf.invtlb_op;
  assign invtlb_asid_o    = w_buf.invtlb_asid;
  assign invtlb_vaddr_o   = w_buf.invtlb_vaddr;
  assign cacop_op_o       = w_buf.cacop_op;
  assign cacop_vaddr_o    = w_buf.cacop_vaddr;
  assign redirect_pc_o    = w_buf.br_target;
  assign retire_rob_idx_o = w_buf.base.rob_idx;
  assign retire_pdest_o   = w_buf.base.pdest;
  assign retire_wdata_o   = w_buf.base.wdata;

`ifdef MISC_CMT_PERF_EN
  logic [31:0] r_perf_br_cnt;
  logic [31:0] r_perf_redirect_cnt;

  // Retired-branch and redirect counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_br_cnt       <= '0;
      r_perf_redirect_cnt <= '0;
    end else if (r_state == ST_RETIRE) begin
      if (w_buf.br_inst) begin
        r_perf_br_cnt <= r_perf_br_cnt + 32'd1;
      end
      if (w_buf.br_inst && w_buf.br_redirect) begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
      end
    end
  end

  assign perf_br_cnt_o       = r_perf_br_cnt;
  assign perf_redirect_cnt_o = r_perf_redirect_cnt;
`endif

endmodule

// File: tb/tb_misc_cmt_unit.sv
// tb/tb_misc_cmt_unit.sv - self-checking bench for misc_cmt_unit
module tb_misc_cmt_unit;
  import misc_cmt_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  MiscCmtSt    cmt_i = '0;
  logic        cmt_ready_o;
  logic        rob_head_valid_i = 1'b0;
  logic [5:0]  rob_head_idx_i = '0;
  logic        csr_we_o;
  logic [13:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        tlbsrch_we_o;
  logic        tlbsrch_found_o;
  logic [3:0]  tlbsrch_idx_o;
  logic        tlbrd_we_o;
  logic [31:0] tlbrd_ehi_o, tlbrd_elo0_o, tlbrd_elo1_o, tlbrd_idx_o;
  logic [9:0]  tlbrd_asid_o;
  logic        invtlb_valid_o;
  logic [4:0]  invtlb_op_o;
  logic [9:0]  invtlb_asid_o;
  logic [31:0] invtlb_vaddr_o;
  logic        invtlb_ready_i = 1'b0;
  logic        cacop_valid_o;
  logic [4:0]  cacop_op_o;
  logic [31:0] cacop_vaddr_o;
  logic        cacop_ready_i = 1'b0;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        retire_valid_o;
  logic [5:0]  retire_rob_idx_o;
  logic        retire_we_o;
  logic [5:0]  retire_pdest_o;
  logic [31:0] retire_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  misc_cmt_unit dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .cmt_i(cmt_i), .cmt_ready_o(cmt_ready_o),
    .rob_head_valid_i(rob_head_valid_i), .rob_head_idx_i(rob_head_idx_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .tlbsrch_we_o(tlbsrch_we_o), .tlbsrch_found_o(tlbsrch_found_o), .tlbsrch_idx_o(tlbsrch_idx_o),
    .tlbrd_we_o(tlbrd_we_o), .tlbrd_ehi_o(tlbrd_ehi_o), .tlbrd_elo0_o(tlbrd_elo0_o),
    .tlbrd_elo1_o(tlbrd_elo1_o), .tlbrd_idx_o(tlbrd_idx_o), .tlbrd_asid_o(tlbrd_asid_o),
    .invtlb_valid_o(invtlb_valid_o), .invtlb_op_o(invtlb_op_o), .invtlb_asid_o(invtlb_asid_o),
    .invtlb_vaddr_o(invtlb_vaddr_o), .invtlb_ready_i(invtlb_ready_i),
    .cacop_valid_o(cacop_valid_o), .cacop_op_o(cacop_op_o), .cacop_vaddr_o(cacop_vaddr_o),
    .cacop_ready_i(cacop_ready_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .retire_valid_o(retire_valid_o), .retire_rob_idx_o(retire_rob_idx_o),
    .retire_we_o(retire_we_o), .retire_pdest_o(retire_pdest_o), .retire_wdata_o(retire_wdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // What one retirement looks like from outside; payloads only count while their strobe is high.
  typedef struct packed {
    logic [5:0]  idx;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        tlbsrch_we;
    logic        found;
    logic [3:0]  sidx;
    logic        tlbrd_we;
    logic [31:0] ehi, elo0, elo1, tidx;
    logic [9:0]  asid;
    logic        redir;
    logic [31:0] pc;
    logic        we;
    logic [5:0]  pdest;
    logic [31:0] wdata;
  } ret_rec_t;

  ret_rec_t    rq[$];
  int          rq_cyc[$];
  int          stray = 0;
  int          cacop_hi = 0, cacop_unstable = 0;
  logic [36:0] cacop_prev = '0;
  int          invtlb_hi = 0, invtlb_unstable = 0;
  logic [46:0] invtlb_prev = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (retire_valid_o) begin
        ret_rec_t r;
        r = '0;
        r.idx = retire_rob_idx_o;
        r.csr_we = csr_we_o;
        if (csr_we_o) begin r.csr_waddr = csr_waddr_o; r.csr_wdata = csr_wdata_o; end
        r.tlbsrch_we = tlbsrch_we_o;
        if (tlbsrch_we_o) begin r.found = tlbsrch_found_o; r.sidx = tlbsrch_idx_o; end
        r.tlbrd_we = tlbrd_we_o;
        if (tlbrd_we_o) begin
          r.ehi = tlbrd_ehi_o; r.elo0 = tlbrd_elo0_o; r.elo1 = tlbrd_elo1_o;
          r.tidx = tlbrd_idx_o; r.asid = tlbrd_asid_o;
        end
        r.redir = redirect_valid_o;
        if (redirect_valid_o) r.pc = redirect_pc_o;
        r.we = retire_we_o;
        if (retire_we_o) begin r.pdest = retire_pdest_o; r.wdata = retire_wdata_o; end
        rq.push_back(r);
        rq_cyc.push_back(cyc);
      end else if (csr_we_o | tlbsrch_we_o | tlbrd_we_o | redirect_valid_o | retire_we_o) begin
        stray++;
      end
      if (cacop_valid_o) begin
        if (cacop_hi > 0 && {cacop_op_o, cacop_vaddr_o} != cacop_prev) cacop_unstable++;
        cacop_prev = {cacop_op_o, cacop_vaddr_o};
        cacop_hi++;
      end
      if (invtlb_valid_o) begin
        if (invtlb_hi > 0 && {invtlb_op_o, invtlb_asid_o, invtlb_vaddr_o} != invtlb_prev) invtlb_unstable++;
        invtlb_prev = {invtlb_op_o, invtlb_asid_o, invtlb_vaddr_o};
        invtlb_hi++;
      end
    end
  end

  task automatic clear_log();
    rq.delete(); rq_cyc.delete(); stray = 0;
    cacop_hi = 0; cacop_unstable = 0; invtlb_hi = 0; invtlb_unstable = 0;
  endtask

  // Expected retirement derived from the commit rules of the packet alone.
  function automatic ret_rec_t model_rec(input MiscCmtSt p);
    ret_rec_t r;
    r = '0;
    r.idx = p.base.rob_idx;
    r.csr_we = p.csr_we;
    if (p.csr_we) begin r.csr_waddr = p.csr_waddr; r.csr_wdata = p.csr_wdata; end
    r.tlbsrch_we = (p.priv_op == PRIV_TLBSRCH);
    if (r.tlbsrch_we) begin r.found = p.tlbsrch_found; r.sidx = p.tlbsrch_idx; end
    r.tlbrd_we = (p.priv_op == PRIV_TLBRD);
    if (r.tlbrd_we) begin
      r.ehi = p.tlbrd_ehi; r.elo0 = p.tlbrd_elo0; r.elo1 = p.tlbrd_elo1;
      r.tidx = p.tlbrd_idx; r.asid = p.tlbrd_asid;
    end
    r.redir = p.br_inst & p.br_redirect;
    if (r.redir) r.pc = p.br_target;
    r.we = p.base.we;
    if (p.base.we) begin r.pdest = p.base.pdest; r.wdata = p.base.wdata; end
    return r;
  endfunction

  // Accept at cycle n; head matches hd cycles late; side request waits rw cycles for ready.
  function automatic int exp_lat(input MiscCmtSt p, input int hd, input int rw);
    if (p.priv_op == PRIV_CACOP || p.priv_op == PRIV_INVTLB) return 3 + hd + rw;
    return 2 + hd;
  endfunction

  function automatic MiscCmtSt rand_pkt(input logic [5:0] idx);
    MiscCmtSt p;
    int k;
    p = '0;
    p.base.valid = 1'b1;
    p.base.rob_idx = idx;
    p.base.we = 1'($urandom_range(0, 1));
    p.base.pdest = 6'($urandom);
    p.base.wdata = $urandom;
    p.br_inst = 1'($urandom_range(0, 1));
    p.br_redirect = 1'($urandom_range(0, 1));
    p.br_target = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: p.priv_op = PRIV_NONE;
      1: p.priv_op = PRIV_CSR_WR;
      2: p.priv_op = PRIV_TLBSRCH;
      3: p.priv_op = PRIV_TLBRD;
      4: p.priv_op = PRIV_INVTLB;
      default: p.priv_op = PRIV_CACOP;
    endcase
    p.csr_we = 1'($urandom_range(0, 1));
    p.csr_waddr = 14'($urandom);
    p.csr_wdata = $urandom;
    p.tlbsrch_found = 1'($urandom_range(0, 1));
    p.tlbsrch_idx = 4'($urandom);
    p.tlbrd_ehi = $urandom; p.tlbrd_elo0 = $urandom; p.tlbrd_elo1 = $urandom;
    p.tlbrd_idx = $urandom; p.tlbrd_asid = 10'($urandom);
    p.invtlb_op = 5'($urandom); p.invtlb_asid = 10'($urandom); p.invtlb_vaddr = $urandom;
    p.cacop_op = 5'($urandom); p.cacop_vaddr = $urandom;
    return p;
  endfunction

  task automatic drive_pkt(input MiscCmtSt p, input int hd, input int rw, output int n);
    @(posedge clk); #1;
    cmt_i = p;
    n = cyc;
    rob_head_valid_i = (hd == 0);
    rob_head_idx_i = (hd == 0) ? p.base.rob_idx : p.base.rob_idx + 6'd1;
    @(posedge clk); #1;
    cmt_i = '0;
    for (int i = 0; i < hd; i++) begin
      rob_head_valid_i = 1'($urandom_range(0, 1));
      rob_head_idx_i = p.base.rob_idx + 6'd1;
      @(posedge clk); #1;
    end
    rob_head_valid_i = 1'b1;
    rob_head_idx_i = p.base.rob_idx;
    @(posedge clk); #1;
    rob_head_valid_i = 1'b0;
    for (int i = 0; i < rw; i++) begin
      @(posedge clk); #1;
    end
    cacop_ready_i = 1'b1;
    invtlb_ready_i = 1'b1;
    @(posedge clk); #1;
    cacop_ready_i = 1'b0;
    invtlb_ready_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmt_i = rand_pkt(6'd3);
    rob_head_valid_i = 1'b1;
    rob_head_idx_i = 6'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmt_ready_o); end
    n_tests++;
    if ({retire_valid_o, csr_we_o, tlbsrch_we_o, tlbrd_we_o, invtlb_valid_o, cacop_valid_o, redirect_valid_o, retire_we_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {retire_valid_o, csr_we_o, tlbsrch_we_o, tlbrd_we_o, invtlb_valid_o, cacop_valid_o, redirect_valid_o, retire_we_o});
    end
    n_tests++;
    if ({csr_wdata_o, redirect_pc_o, retire_wdata_o, tlbrd_ehi_o, cacop_vaddr_o} !== 160'h0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h expected 0", {csr_wdata_o, redirect_pc_o, retire_wdata_o, tlbrd_ehi_o, cacop_vaddr_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmt_i = '0;
    rob_head_valid_i = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1 || rq.size() != 0) begin
      n_fail++; $display("FAIL reset_release: ready %b retires %0d expected 1/0", cmt_ready_o, rq.size());
    end
  endtask

  task automatic test_csr_write();
    MiscCmtSt p;
    int n;
    clear_log();
    p = '0;
    p.base.valid = 1'b1; p.base.rob_idx = 6'd5; p.priv_op = PRIV_CSR_WR;
    p.csr_we = 1'b1; p.csr_waddr = 14'h180; p.csr_wdata = 32'hDEAD_0000;
    @(posedge clk); #1;
    cmt_i = p; rob_head_valid_i = 1'b1; rob_head_idx_i = 6'd5; n = cyc;
    @(posedge clk); #1;
    cmt_i = '0;
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b0) begin n_fail++; $display("FAIL csr_ready_n1: got %b expected 0", cmt_ready_o); end
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b0) begin n_fail++; $display("FAIL csr_ready_n2: got %b expected 0", cmt_ready_o); end
    n_tests++;
    if ({retire_valid_o, csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, 1'b1, 14'h180, 32'hDEAD_0000}) begin
      n_fail++;
      $display("FAIL csr_pulse: got rv=%b we=%b a=%h d=%h expected 1 1 180 dead0000", retire_valid_o, csr_we_o, csr_waddr_o, csr_wdata_o);
    end
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1 || csr_we_o !== 1'b0) begin
      n_fail++; $display("FAIL csr_after: ready %b we %b expected 1 0", cmt_ready_o, csr_we_o);
    end
    rob_head_valid_i = 1'b0;
    n_tests++;
    if (rq.size() != 1 || rq_cyc[0] != n + 2) begin
      n_fail++; $display("FAIL csr_latency: got %0d retires first at %0d expected 1 at %0d", rq.size(), (rq.size() > 0) ? rq_cyc[0] - n : -1, 2);
    end
  endtask

  task automatic test_branch_late_head();
    MiscCmtSt p;
    int n;
    clear_log();
    p = '0;
    p.base.valid = 1'b1; p.base.rob_idx = 6'd17; p.priv_op = PRIV_NONE;
    p.br_inst = 1'b1; p.br_redirect = 1'b1; p.br_target = 32'h1C00_0040;
    drive_pkt(p, 4, 0, n);
    n_tests++;
    if (rq.size() != 1) begin
      n_fail++; $display("FAIL branch_count: got %0d retires expected 1", rq.size());
    end else begin
      n_tests++;
      if (rq_cyc[0] != n + 6) begin n_fail++; $display("FAIL branch_latency: got %0d expected 6", rq_cyc[0] - n); end
      n_tests++;
      if ({rq[0].redir, rq[0].pc} !== {1'b1, 32'h1C00_0040}) begin
        n_fail++; $display("FAIL branch_redirect: got %b %h expected 1 1c000040", rq[0].redir, rq[0].pc);
      end
    end
    n_tests++;
    if (stray != 0) begin n_fail++; $display("FAIL branch_stray: got %0d expected 0", stray); end
  endtask

  task automatic test_cacop_stall();
    MiscCmtSt p;
    int n;
    clear_log();
    p = '0;
    p.base.valid = 1'b1; p.base.rob_idx = 6'd40; p.priv_op = PRIV_CACOP;
    p.cacop_op = 5'd9; p.cacop_vaddr = 32'h8000_1000;
    drive_pkt(p, 0, 3, n);
    n_tests++;
    if (cacop_hi != 4 || cacop_unstable != 0) begin
      n_fail++; $display("FAIL cacop_hold: got %0d cycles %0d changes expected 4 0", cacop_hi, cacop_unstable);
    end
    n_tests++;
    if (cacop_prev !== {5'd9, 32'h8000_1000}) begin n_fail++; $display("FAIL cacop_payload: got %h expected %h", cacop_prev, {5'd9, 32'h8000_1000}); end
    n_tests++;
    if (rq.size() != 1 || rq_cyc[0] != n + 6) begin
      n_fail++; $display("FAIL cacop_retire: got %0d retires expected 1 at +6", rq.size());
    end
  endtask

  task automatic test_invtlb_flush();
    MiscCmtSt p;
    clear_log();
    p = '0;
    p.base.valid = 1'b1; p.base.rob_idx = 6'd9; p.priv_op = PRIV_INVTLB;
    p.invtlb_op = 5'd5; p.invtlb_asid = 10'h3A; p.invtlb_vaddr = 32'h1234_5000; p.base.we = 1'b1;
    @(posedge clk); #1;
    cmt_i = p; rob_head_valid_i = 1'b1; rob_head_idx_i = 6'd9;
    @(posedge clk); #1; cmt_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    @(posedge clk); #1; invtlb_ready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b0 || invtlb_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL invtlb_held: ready %b valid %b expected 0 1", cmt_ready_o, invtlb_valid_o);
    end
    @(posedge clk); #1; invtlb_ready_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1 || invtlb_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL invtlb_release: ready %b valid %b expected 1 0", cmt_ready_o, invtlb_valid_o);
    end
    repeat (4) @(negedge clk);
    rob_head_valid_i = 1'b0;
    n_tests++;
    if (invtlb_hi != 4 || invtlb_unstable != 0 || invtlb_prev !== {5'd5, 10'h3A, 32'h1234_5000}) begin
      n_fail++; $display("FAIL invtlb_req: got %0d cycles %0d changes %h expected 4 0 %h", invtlb_hi, invtlb_unstable, invtlb_prev, {5'd5, 10'h3A, 32'h1234_5000});
    end
    n_tests++;
    if (rq.size() != 0 || stray != 0) begin
      n_fail++; $display("FAIL invtlb_no_retire: got %0d retires %0d strobes expected 0 0", rq.size(), stray);
    end
  endtask

  task automatic test_tlbsrch_tlbrd();
    MiscCmtSt p0, p1;
    int n;
    clear_log();
    p0 = rand_pkt(6'd50); p0.priv_op = PRIV_TLBSRCH; p0.tlbsrch_found = 1'b0; p0.tlbsrch_idx = 4'd7;
    p1 = rand_pkt(6'd51); p1.priv_op = PRIV_TLBRD;
    drive_pkt(p0, 1, 0, n);
    drive_pkt(p1, 0, 0, n);
    n_tests++;
    if (rq.size() != 2) begin
      n_fail++; $display("FAIL tlb_count: got %0d retires expected 2", rq.size());
    end else begin
      n_tests++;
      if ({rq[0].tlbsrch_we, rq[0].found, rq[0].tlbrd_we} !== 3'b100) begin
        n_fail++; $display("FAIL tlbsrch_pulse: got %b expected 100", {rq[0].tlbsrch_we, rq[0].found, rq[0].tlbrd_we});
      end
      n_tests++;
      if ({rq[1].tlbrd_we, rq[1].ehi, rq[1].elo0, rq[1].elo1, rq[1].asid} !== {1'b1, p1.tlbrd_ehi, p1.tlbrd_elo0, p1.tlbrd_elo1, p1.tlbrd_asid}) begin
        n_fail++; $display("FAIL tlbrd_values: got %h expected %h", {rq[1].tlbrd_we, rq[1].ehi, rq[1].elo0, rq[1].elo1, rq[1].asid},
                           {1'b1, p1.tlbrd_ehi, p1.tlbrd_elo0, p1.tlbrd_elo1, p1.tlbrd_asid});
      end
    end
  endtask

  task automatic test_flush();
    clear_log();
    @(posedge clk); #1;
    cmt_i = rand_pkt(6'd12); cmt_i.priv_op = PRIV_NONE; flush_i = 1'b1;
    rob_head_valid_i = 1'b1; rob_head_idx_i = 6'd12;
    @(posedge clk); #1;
    cmt_i = '0; flush_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_accept_ready: got %b expected 1", cmt_ready_o); end
    repeat (5) @(negedge clk);
    n_tests++;
    if (rq.size() != 0) begin n_fail++; $display("FAIL flush_accept_retire: got %0d retires expected 0", rq.size()); end
    @(posedge clk); #1;
    cmt_i = rand_pkt(6'd30); cmt_i.priv_op = PRIV_CSR_WR; rob_head_valid_i = 1'b0;
    @(posedge clk); #1;
    cmt_i = '0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; rob_head_valid_i = 1'b1; rob_head_idx_i = 6'd30;
    @(negedge clk);
    n_tests++;
    if (cmt_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_head_ready: got %b expected 1", cmt_ready_o); end
    repeat (4) @(negedge clk);
    rob_head_valid_i = 1'b0;
    n_tests++;
    if (rq.size() != 0 || stray != 0) begin
      n_fail++; $display("FAIL flush_head_retire: got %0d retires %0d strobes expected 0 0", rq.size(), stray);
    end
  endtask

  task automatic test_back_to_back();
    MiscCmtSt p;
    int n;
    clear_log();
    p = '0;
    p.base.valid = 1'b1; p.base.rob_idx = 6'd20; p.priv_op = PRIV_CSR_WR; p.csr_we = 1'b1;
    @(posedge clk); #1;
    cmt_i = p; rob_head_valid_i = 1'b1; rob_head_idx_i = 6'd20; n = cyc;
    repeat (9) begin @(posedge clk); #1; end
    cmt_i = '0;
    repeat (3) @(negedge clk);
    rob_head_valid_i = 1'b0;
    n_tests++;
    if (rq.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d retires expected 3", rq.size());
    end else begin
      n_tests++;
      if (rq_cyc[0] != n + 2 || rq_cyc[1] != n + 5 || rq_cyc[2] != n + 8) begin
        n_fail++; $display("FAIL b2b_spacing: got +%0d +%0d +%0d expected +2 +5 +8", rq_cyc[0] - n, rq_cyc[1] - n, rq_cyc[2] - n);
      end
    end
  endtask

  task automatic test_random();
    MiscCmtSt p;
    ret_rec_t e;
    int n, hd, rw;
    for (int t = 0; t < 40; t++) begin
      clear_log();
      p = rand_pkt(6'($urandom));
      hd = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      e = model_rec(p);
      drive_pkt(p, hd, rw, n);
      n_tests++;
      if (rq.size() != 1) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d retires expected 1", t, rq.size());
      end else begin
        n_tests++;
        if (rq[0] !== e) begin n_fail++; $display("FAIL rand%0d_record: got %h expected %h", t, rq[0], e); end
        n_tests++;
        if (rq_cyc[0] - n != exp_lat(p, hd, rw)) begin
          n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, rq_cyc[0] - n, exp_lat(p, hd, rw));
        end
      end
      @(negedge clk);
      n_tests++;
      if (cmt_ready_o !== 1'b1 || stray != 0) begin
        n_fail++; $display("FAIL rand%0d_idle: ready %b strobes %0d expected 1 0", t, cmt_ready_o, stray);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_csr_write();
    test_branch_late_head();
    test_cacop_stall();
    test_invtlb_flush();
    test_tlbsrch_tlbrd();
    test_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/misc_cmt_unit.md
Name: misc_cmt_unit

Overview:
Commit-side consumer of the misc execution pipe's MiscCmtSt result stream. It is the responder on the cmt valid/ready handshake. It buffers one branch/privileged result and holds it until that instruction reaches the ROB head. It then performs the architectural side effects in order: CSR write, TLBSRCH/TLBRD CSR update, INVTLB and CACOP requests, branch redirect. Finally it retires the entry to the ROB.

Parameters:
ROB_IDX_W, 6, ROB index width; must match MiscCmtSt.base.rob_idx
PREG_W, 6, physical register index width
VALEN, `PROC_VALEN, virtual address / PC width
TLB_IDX_W, $clog2(`TLB_ENTRY_NUM), TLB index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
flush_i  in  1  pipeline flush, synchronous
cmt_i  in  $bits(MiscCmtSt)  result packet; cmt_i.base.valid is the valid bit
cmt_ready_o  out  1  buffer can accept
rob_head_valid_i  in  1  ROB head entry valid
rob_head_idx_i  in  ROB_IDX_W  ROB head index
csr_we_o / csr_waddr_o / csr_wdata_o  out  1/14/32  CSR write port
tlbsrch_we_o / tlbsrch_found_o / tlbsrch_idx_o  out  1/1/TLB_IDX_W  TLBIDX update from TLBSRCH
tlbrd_we_o  out  1  TLBRD CSR update strobe
tlbrd_ehi_o / tlbrd_elo0_o / tlbrd_elo1_o / tlbrd_idx_o  out  32 each  TLBRD values
tlbrd_asid_o  out  10  TLBRD ASID
invtlb_valid_o / invtlb_op_o / invtlb_asid_o / invtlb_vaddr_o  out  1/5/10/VALEN  INVTLB request
invtlb_ready_i  in  1  INVTLB accepted
cacop_valid_o / cacop_op_o / cacop_vaddr_o  out  1/5/VALEN  CACOP request
cacop_ready_i  in  1  CACOP accepted
redirect_valid_o / redirect_pc_o  out  1/VALEN  frontend redirect
retire_valid_o / retire_rob_idx_o  out  1/ROB_IDX_W  retire to ROB
retire_we_o / retire_pdest_o / retire_wdata_o  out  1/PREG_W/32  writeback

Behaviour:
- States: IDLE, HEAD, CACHE, TLB, RETIRE. Reset: state IDLE, buffer cleared, drop flag 0. Every output except cmt_ready_o resets to 0. cmt_ready_o = (state==IDLE), so it reads 1 after reset.
- IDLE: when cmt_i.base.valid is high, latch the packet into the buffer and go to HEAD.
- HEAD: wait for rob_head_valid_i & rob_head_idx_i == buf.base.rob_idx.
  - priv CACOP goes to CACHE.
  - priv INVTLB goes to TLB.
  - Anything else goes to RETIRE.
- CACHE: hold cacop_valid_o and its payload stable until cacop_ready_i, then go to RETIRE. TLB behaves the same with invtlb_valid_o / invtlb_ready_i.
- RETIRE lasts exactly one cycle, then IDLE. Combinational single-cycle pulses in RETIRE:
  - retire_valid_o, always.
  - csr_we_o = buf.csr_we.
  - tlbsrch_we_o for priv TLBSRCH.
  - tlbrd_we_o for priv TLBRD.
  - redirect_valid_o = buf.br_inst & buf.br_redirect, with redirect_pc_o = buf.br_target.
  - retire_we_o = buf.base.we.
- Latency: packet accepted in cycle N with head already matching gives retire in N+2. Minimum issue interval is 3 cycles; there is no back-to-back acceptance.
- Flush:
  - In IDLE/HEAD/RETIRE: next state IDLE, buffer invalidated, no pulses in the following cycle. Flush outranks acceptance.
  - In CACHE/TLB: the drop flag is set and the request stays asserted until its ready. The unit then returns to IDLE with no retire.
- Payload outputs are don't-care while their strobe is low, but are driven from the buffer (no X).
- An invalid cmt_i (base.valid=0) is never accepted.

Optional Feature:
MISC_CMT_PERF_EN
- Defined: adds outputs perf_br_cnt_o[31:0] (retired branches) and perf_redirect_cnt_o[31:0] (redirects issued). Both increment on the RETIRE cycle, reset to 0, and wrap at 2^32.
- Undefined: ports and counters are absent.

Decomposition:
- MiscCmtSt, PrivOpType and the `PRIV_* / `BR_INST encodings are reused from Pipeline.svh / Decoder.svh.
- The state enum MiscCmtStateT goes into Pipeline.svh.
- One sub-module, misc_cmt_buf: the single-entry valid/ready skid holding the packet plus the drop flag.

Test Plan:
1. CSR_WRITE (rob_idx 5, waddr 0x180, wdata 0xDEAD_0000) with head=5 already valid -> csr_we_o and retire_valid_o pulse together in cycle N+2; cmt_ready_o=0 for N+1..N+2.
2. Branch, br_redirect=1, target 0x1C00_0040, head arrives 4 cycles late -> unit stays in HEAD; then one cycle of redirect_valid_o with pc 0x1C00_0040 plus retire.
3. CACOP vaddr 0x8000_1000, cacop_ready_i low for 3 cycles -> cacop_valid_o held stable for 4 cycles; retire one cycle after ready.
4. INVTLB op 5, asid 0x3A, flush in TLB state -> invtlb_valid_o stays high until invtlb_ready_i; no retire; cmt_ready_o=1 next cycle.
5. TLBSRCH found=0 then TLBRD -> tlbsrch_we_o with found_o=0; then tlbrd_we_o with latched ehi/elo/asid equal to the packet values.
6. Flush in the same cycle as a valid cmt_i -> packet not accepted, and no retire ever appears for its rob_idx.
